edge_pulse_scheduler: RTL and testbench
=======================================

// Module: edge_pulse_scheduler
// PURPOSE
// Clocked replacement for the inverter-chain/XOR edge-pulse generator. Detects
// toggles on N input channels (XOR of input vs. registered copy), queues one
// pending request per channel, and shares one pulse output between channels
// by round-robin. Each pulse has a programmable width and is followed by a
// fixed guard gap. Sits between the stimulus sources and the pulse consumer.
// PARAMETERS
// N_CH    4  number of input channels, 2..16
// W_BITS  4  width of the pulse_width port
// GAP     2  idle cycles forced after each pulse, 0..15
// SRC_W   2  width of pulse_src, = clog2(N_CH)
// PORTS
// clk          in   1       rising-edge clock
// rst_n        in   1       synchronous reset, active-low
// sig_in       in   N_CH    channel inputs, synchronous to clk
// enable       in   1       1 = grants allowed; edges are recorded regardless
// pulse_width  in   W_BITS  pulse length in cycles; 0 is treated as 1
// pulse_out    out  1       shared pulse, registered
// pulse_src    out  SRC_W   channel owning the current or last pulse
// busy         out  1       FSM not in IDLE
// pending      out  N_CH    queued requests, one bit per channel
// overflow     out  1       one-cycle flag: edge on an already-pending channel
// BEHAVIOUR
// Reset (rst_n=0 at a clk edge):
// - sig_q<=sig_in, so no edge is seen after reset; pending=0; FSM=IDLE.
// - pulse_out=0, pulse_src=0, busy=0, overflow=0, rr pointer=0.
// - Reset mid-pulse aborts immediately; queued requests are lost.
// Edge detect, every clk: edge[i]=sig_in[i]^sig_q[i]; then sig_q<=sig_in.
// - Edge on a non-pending channel: pending[i]<=1.
// - Edge on a pending channel not being granted this cycle: pending stays 1,
//   overflow<=1 for one cycle.
// - Edge on the channel being granted this cycle: pending[i] stays 1 (new
//   request); no overflow.
// FSM states: IDLE, PULSE, GAP. cnt is a W_BITS counter.
// - IDLE: if enable and |pending, grant the first set bit searching from
//   rr+1 upward, wrapping at N_CH-1->0. On the grant:
//   pending[g]<=0 (unless a re-edge, see above), pulse_src<=g, rr<=g,
//   cnt<=max(pulse_width,1), pulse_out<=1, go to PULSE.
//   pulse_width is sampled only at the grant.
// - PULSE: cnt<=cnt-1. When cnt==1: pulse_out<=0; go to GAP if GAP>0,
//   else IDLE. pulse_out is high for exactly max(pulse_width,1) cycles.
// - GAP: count GAP cycles with pulse_out=0, then go to IDLE.
// - No grant is possible until the cycle after entering IDLE.
// Latency:
// - sig_in toggles before edge E0: pending set at E0, grant at E1,
//   pulse_out high E1..E1+W.
// - Minimum spacing between pulse starts is W+GAP+1 cycles.
// enable:
// - Dropping enable never truncates a pulse or gap; it only blocks grants
//   in IDLE.
// busy=1 in PULSE and GAP. pulse_src holds its value after the pulse ends.
// TESTING
// 1 Reset with sig_in=4'b1010, release, hold sig_in
//   -> pending=0, pulse_out never rises.
// 2 pulse_width=3, GAP=2, toggle ch1 once -> pending[1] one cycle later;
//   pulse_out high for exactly 3 cycles starting 2 edges after the toggle;
//   pulse_src=1; busy high 5 cycles.
// 3 Toggle ch0,ch2,ch3 in the same cycle, rr=0
//   -> pulses granted in order 2,3,0, each 3 wide with a 2-cycle gap.
// 4 Toggle ch1 twice while ch1 is pending, before grant
//   -> overflow pulses once; only one ch1 pulse is issued.
// 5 pulse_width=0 -> 1-cycle pulse. enable=0 with ch3 pending -> no pulse;
//   set enable=1 -> pulse issued on the next edge.
// 6 Assert rst_n=0 mid-PULSE -> pulse_out=0, pending=0, busy=0 at that edge.

Source files
------------

// File: rtl/edge_pulse_scheduler.sv
// ============================================================================
// Module      : edge_pulse_scheduler
// Description : Clocked multi-channel edge-pulse generator. Toggles on sig_in
//               are detected against a registered copy. Each toggle queues one
//               request per channel. A single shared, registered pulse output
//               is granted round-robin, with a programmable pulse width and a
//               fixed guard gap after every pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_pulse_scheduler #(
  parameter int N_CH   = 4,
  parameter int W_BITS = 4,
  parameter int GAP    = 2,
  parameter int SRC_W  = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   sig_in,
  input  logic              enable,
  input  logic [W_BITS-1:0] pulse_width,
  output logic              pulse_out,
  output logic [SRC_W-1:0]  pulse_src,
  output logic              busy,
  output logic [N_CH-1:0]   pending,
  output logic              overflow
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PULSE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  localparam logic       HAS_GAP = (GAP > 0);
  localparam logic [3:0] GAP_LD  = 4'(GAP);

  logic [1:0]        state;
  logic [1:0]        state_nx;
  logic [N_CH-1:0]   sig_q;
  logic [N_CH-1:0]   edges;
  logic [W_BITS-1:0] cnt;
  logic [W_BITS-1:0] cnt_nx;
  logic [3:0]        gap_cnt;
  logic [3:0]        gap_nx;
  logic [SRC_W-1:0]  rr;
  logic [SRC_W-1:0]  rr_nx;
  logic [SRC_W-1:0]  src_nx;
  logic              pulse_out_nx;
  logic [N_CH-1:0]   pending_nx;
  logic              overflow_nx;
  logic              grant_found;
  logic              grant_valid;
  logic [SRC_W-1:0]  grant_idx;
  logic [N_CH-1:0]   grant_mask;

  // A toggle is any difference between the live input and last cycle's copy.
  assign edges = sig_in ^ sig_q;
  assign busy  = (state != S_IDLE);

  // Round-robin search: first pending channel after the last grant, wrapping.
  always_comb begin
    int               idx;
    logic [SRC_W-1:0] idx_s;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    idx_s       = '0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = int'(rr) + k;
      if (idx >= N_CH) begin
        idx = idx - N_CH;
      end
      idx_s = idx[SRC_W-1:0];
      if (!grant_found && pending[idx_s]) begin
        grant_found = 1'b1;
        grant_idx   = idx_s;
      end
    end
    grant_valid = grant_found && enable && (state == S_IDLE);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // FSM next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (grant_valid) state_nx = S_PULSE;
      S_PULSE: if (cnt == W_BITS'(1)) state_nx = HAS_GAP ? S_GAP : S_IDLE;
      S_GAP:   if (gap_cnt == 4'd1) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // FSM outputs: next values of the pulse, counters and request queue.
  always_comb begin
    cnt_nx       = cnt;
    gap_nx       = gap_cnt;
    rr_nx        = rr;
    src_nx       = pulse_src;
    pulse_out_nx = pulse_out;
    grant_mask   = '0;
    if (grant_valid) begin
      grant_mask[grant_idx] = 1'b1;
    end
    // A re-edge on the granted channel re-queues it; the grant does not
    // count as a collision, so it is masked out of the overflow check.
    pending_nx  = (pending & ~grant_mask) | edges;
    overflow_nx = |(edges & pending & ~grant_mask);
    case (state)
      S_IDLE: begin
        if (grant_valid) begin
          src_nx       = grant_idx;
          rr_nx        = grant_idx;
          cnt_nx       = (pulse_width == '0) ? W_BITS'(1) : pulse_width;
          pulse_out_nx = 1'b1;
        end
      end
      S_PULSE: begin
        cnt_nx = cnt - W_BITS'(1);
        if (cnt == W_BITS'(1)) begin
          pulse_out_nx = 1'b0;
          gap_nx       = GAP_LD;
        end
      end
      S_GAP: begin
        gap_nx = gap_cnt - 4'd1;
      end
      default: begin
        pulse_out_nx = 1'b0;
      end
    endcase
  end

  // Datapath registers; reset re-seeds sig_q so no edge appears on release.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig_q     <= sig_in;
      pending   <= '0;
      overflow  <= 1'b0;
      pulse_out <= 1'b0;
      pulse_src <= '0;
      rr        <= '0;
      cnt       <= '0;
      gap_cnt   <= '0;
    end else begin
      sig_q     <= sig_in;
      pending   <= pending_nx;
      overflow  <= overflow_nx;
      pulse_out <= pulse_out_nx;
      pulse_src <= src_nx;
      rr        <= rr_nx;
      cnt       <= cnt_nx;
      gap_cnt   <= gap_nx;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_edge_pulse_scheduler.sv
// ============================================================================
// Module      : tb_edge_pulse_scheduler
// Description : Self-checking bench for edge_pulse_scheduler. Expected pulses
//               (source, width) are queued as stimulus is applied and popped
//               by a monitor when each pulse on pulse_out completes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_edge_pulse_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sig_in;
  logic       enable;
  logic [3:0] pulse_width;
  logic       pulse_out;
  logic [1:0] pulse_src;
  logic       busy;
  logic [3:0] pending;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [1:0] exp_src_q[$];
  int         exp_w_q[$];
  int         start_q[$];

  logic       mon_ignore = 1'b1;
  logic       in_pulse   = 1'b0;
  int         wcount     = 0;
  logic [1:0] cur_src    = 2'd0;

  edge_pulse_scheduler #(
    .N_CH(4), .W_BITS(4), .GAP(2), .SRC_W(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .enable(enable),
    .pulse_width(pulse_width), .pulse_out(pulse_out), .pulse_src(pulse_src),
    .busy(busy), .pending(pending), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Cycle counter advanced on every active edge.
  always @(posedge clk) cyc++;

  // Monitor: measure each pulse and compare against the scoreboard.
  always @(negedge clk) begin
    if (mon_ignore || !rst_n) begin
      in_pulse = 1'b0;
      wcount   = 0;
    end else if (pulse_out === 1'b1) begin
      if (!in_pulse) begin
        in_pulse = 1'b1;
        wcount   = 1;
        cur_src  = pulse_src;
        start_q.push_back(cyc);
      end else begin
        wcount++;
      end
    end else if (in_pulse) begin
      in_pulse = 1'b0;
      n_checks++;
      if (exp_src_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: got src=%0d width=%0d, required no pulse",
                 cur_src, wcount);
      end else begin
        logic [1:0] e_src;
        int         e_w;
        e_src = exp_src_q.pop_front();
        e_w   = exp_w_q.pop_front();
        if (cur_src !== e_src || wcount !== e_w) begin
          n_fail++;
          $display("FAIL scoreboard_pulse: got src=%0d width=%0d, required src=%0d width=%0d",
                   cur_src, wcount, e_src, e_w);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_pulse(input logic [1:0] src, input int w);
    exp_src_q.push_back(src);
    exp_w_q.push_back(w);
  endtask

  task automatic wait_drain(input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      if (exp_src_q.size() == 0 && busy === 1'b0 && !in_pulse) done = 1'b1;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d pulses still outstanding, required 0",
               exp_src_q.size());
    end
  endtask

  task automatic test_reset();
    logic rose;
    rst_n = 1'b0; sig_in = 4'b1010; enable = 1'b1; pulse_width = 4'd3;
    tick();
    n_checks++;
    if (pulse_out !== 1'b0 || busy !== 1'b0 || pending !== 4'b0000 ||
        pulse_src !== 2'd0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got po=%b busy=%b pend=%b src=%0d ov=%b, required all 0",
               pulse_out, busy, pending, pulse_src, overflow);
    end
    tick(); tick();
    rst_n = 1'b1;
    mon_ignore = 1'b0;
    rose = 1'b0;
    repeat (10) begin
      tick();
      rose = rose | (pulse_out === 1'b1);
    end
    n_checks++;
    if (rose !== 1'b0 || pending !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_release: got rose=%b pend=%b, required rose=0 pend=0000",
               rose, pending);
    end
  endtask

  task automatic test_single();
    logic [7:0] p_obs, b_obs;
    sig_in[1] = ~sig_in[1];
    expect_pulse(2'd1, 3);
    for (int i = 0; i < 8; i++) begin
      tick();
      p_obs[i] = pulse_out;
      b_obs[i] = busy;
      if (i == 0) begin
        n_checks++;
        if (pending !== 4'b0010) begin
          n_fail++;
          $display("FAIL single_pending: got %b, required 0010", pending);
        end
      end
      if (i == 1) begin
        n_checks++;
        if (pulse_src !== 2'd1 || pending !== 4'b0000) begin
          n_fail++;
          $display("FAIL single_grant: got src=%0d pend=%b, required src=1 pend=0000",
                   pulse_src, pending);
        end
      end
    end
    n_checks++;
    if (p_obs !== 8'b0000_1110) begin
      n_fail++;
      $display("FAIL single_pulse_shape: got %b, required 00001110", p_obs);
    end
    n_checks++;
    if (b_obs !== 8'b0011_1110) begin
      n_fail++;
      $display("FAIL single_busy_shape: got %b, required 00111110", b_obs);
    end
    wait_drain(20);
  endtask

  task automatic test_multi();
    int t0;
    start_q.delete();
    t0 = cyc;
    sig_in = sig_in ^ 4'b1101;
    expect_pulse(2'd2, 3);
    expect_pulse(2'd3, 3);
    expect_pulse(2'd0, 3);
    wait_drain(80);
    n_checks++;
    if (start_q.size() != 3) begin
      n_fail++;
      $display("FAIL multi_count: got %0d pulse starts, required 3", start_q.size());
    end else begin
      if (start_q[0] != t0 + 2) begin
        n_fail++;
        $display("FAIL multi_latency: got start at +%0d, required +2", start_q[0] - t0);
      end
      n_checks++;
      if (start_q[1] - start_q[0] != 6 || start_q[2] - start_q[1] != 6) begin
        n_fail++;
        $display("FAIL multi_spacing: got %0d,%0d, required 6,6",
                 start_q[1] - start_q[0], start_q[2] - start_q[1]);
      end
    end
  endtask

  task automatic test_overflow();
    int ovcnt;
    enable = 1'b0;
    pulse_width = 4'd3;
    sig_in[1] = ~sig_in[1];
    tick();
    n_checks++;
    if (pending !== 4'b0010) begin
      n_fail++;
      $display("FAIL ovf_pending: got %b, required 0010", pending);
    end
    ovcnt = (overflow === 1'b1) ? 1 : 0;
    sig_in[1] = ~sig_in[1];
    repeat (3) begin
      tick();
      if (overflow === 1'b1) ovcnt++;
    end
    n_checks++;
    if (ovcnt != 1 || pending !== 4'b0010 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_flag: got ov_cycles=%0d pend=%b busy=%b, required 1 0010 0",
               ovcnt, pending, busy);
    end
    expect_pulse(2'd1, 3);
    enable = 1'b1;
    wait_drain(30);
    repeat (10) tick();
    n_checks++;
    if (pending !== 4'b0000) begin
      n_fail++;
      $display("FAIL ovf_single_pulse: got pend=%b, required 0000", pending);
    end
  endtask

  task automatic test_width0_enable();
    pulse_width = 4'd0;
    enable = 1'b1;
    sig_in[2] = ~sig_in[2];
    expect_pulse(2'd2, 1);
    wait_drain(20);
    enable = 1'b0;
    sig_in[3] = ~sig_in[3];
    repeat (8) tick();
    n_checks++;
    if (pending !== 4'b1000 || busy !== 1'b0 || pulse_out !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_block: got pend=%b busy=%b po=%b, required 1000 0 0",
               pending, busy, pulse_out);
    end
    expect_pulse(2'd3, 1);
    enable = 1'b1;
    tick();
    n_checks++;
    if (pulse_out !== 1'b1 || pulse_src !== 2'd3) begin
      n_fail++;
      $display("FAIL enable_grant: got po=%b src=%0d, required po=1 src=3",
               pulse_out, pulse_src);
    end
    tick();
    n_checks++;
    if (pulse_out !== 1'b0) begin
      n_fail++;
      $display("FAIL width0_len: got po=%b after one cycle, required 0", pulse_out);
    end
    wait_drain(20);
  endtask

  task automatic test_reset_mid();
    logic rose;
    mon_ignore = 1'b1;
    pulse_width = 4'd5;
    enable = 1'b1;
    sig_in = sig_in ^ 4'b0011;
    tick();
    tick();
    n_checks++;
    if (pulse_out !== 1'b1 || busy !== 1'b1 || pending !== 4'b0010) begin
      n_fail++;
      $display("FAIL mid_pulse_start: got po=%b busy=%b pend=%b, required 1 1 0010",
               pulse_out, busy, pending);
    end
    tick();
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (pulse_out !== 1'b0 || pending !== 4'b0000 || busy !== 1'b0 || pulse_src !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_reset_abort: got po=%b pend=%b busy=%b src=%0d, required 0 0000 0 0",
               pulse_out, pending, busy, pulse_src);
    end
    rst_n = 1'b1;
    mon_ignore = 1'b0;
    rose = 1'b0;
    repeat (12) begin
      tick();
      rose = rose | (pulse_out === 1'b1);
    end
    n_checks++;
    if (rose !== 1'b0 || pending !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_reset_lost: got rose=%b pend=%b, required 0 0000", rose, pending);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_overflow();
    test_width0_enable();
    test_reset_mid();
    n_checks++;
    if (exp_src_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %0d leftover, required 0", exp_src_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop in case the run wedges somewhere unbounded.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
